// File: rtl/mac_pipe_n_if.sv
// mac_pipe_n_if: input beat, output beat and accumulator status of mac_pipe_n.
// slave is the datapath side, master is the producer/consumer side.
interface mac_pipe_n_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int ACC_W  = 20
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic              mode;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc;
  logic              ovf;

  modport slave (
    input  a, b, c, mode, clr, in_valid, out_ready,
    output in_ready, out_data, out_valid, acc, ovf
  );

  modport master (
    output a, b, c, mode, clr, in_valid, out_ready,
    input  in_ready, out_data, out_valid, acc, ovf
  );
endinterface

// File: rtl/mac_pipe_n.sv
// mac_pipe_n: two-stage a*b+c / accumulate pipeline with valid/ready flow.
// Define MAC_PIPE_SAT_EN to saturate out_data and acc instead of wrapping.
module mac_pipe_n #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int ACC_W  = 20
) (
  input  logic         clk,
  input  logic         reset,
  mac_pipe_n_if.slave  bus
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;
  localparam int NW = ACC_W + 1;

  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic              mode_q, clr_q;
  logic              s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  logic              s2_free, adv, accept;
  logic [PW-1:0]     prod;
  logic [SW-1:0]     sum0;
  logic [ACC_W-1:0]  base;
  logic [NW-1:0]     nsum;

  // in_ready looks straight through to out_ready so a full pipe
  // can still take a beat on the cycle it drains.
  assign s2_free      = !out_valid_q || bus.out_ready;
  assign adv          = s1_valid_q && s2_free;
  assign bus.in_ready = !s1_valid_q || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  assign prod = PW'(a_q) * PW'(b_q);
  assign sum0 = SW'(prod) + SW'(c_q);
  assign base = clr_q ? '0 : acc_q;
  assign nsum = NW'(base) + NW'(prod);

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    s1_valid_d  = accept || (s1_valid_q && !adv);
    out_valid_d = adv || (out_valid_q && !bus.out_ready);
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (adv) begin
      if (!mode_q) begin
`ifdef MAC_PIPE_SAT_EN
        out_data_d = ((sum0 >> OUT_W) != '0) ? '1 : OUT_W'(sum0);
`else
        out_data_d = OUT_W'(sum0);
`endif
      end else begin
`ifdef MAC_PIPE_SAT_EN
        out_data_d = ((nsum >> OUT_W) != '0) ? '1 : OUT_W'(nsum);
        acc_d      = nsum[ACC_W] ? '1 : ACC_W'(nsum);
`else
        out_data_d = OUT_W'(nsum);
        acc_d      = ACC_W'(nsum);
`endif
        ovf_d      = (ovf_q && !clr_q) || nsum[ACC_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      mode_q      <= 1'b0;
      clr_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= bus.a;
        b_q    <= bus.b;
        c_q    <= bus.c;
        mode_q <= bus.mode;
        clr_q  <= bus.clr;
      end
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mac_pipe_n.sv
// tb_mac_pipe_n: directed plan cases plus random traffic vs a queue model.
// Build with +define+MAC_PIPE_SAT_EN to check the saturating variant.
module tb_mac_pipe_n;
  localparam int DW = 8;
  localparam int OW = 8;
  localparam int AW = 20;

  typedef struct {
    logic [OW-1:0] d;
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mac_pipe_n_if #(.DATA_W(DW), .OUT_W(OW), .ACC_W(AW)) bus ();

  mac_pipe_n #(.DATA_W(DW), .OUT_W(OW), .ACC_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t   exp_q[$];
  longint m_acc = 0;
  logic   m_ovf = 1'b0;
  int     n_chk = 0;
  int     n_pass = 0;
  int     n_out = 0;
  logic [OW-1:0] last_out;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic void model(input logic [7:0] a, b, c,
                                input logic m, cl);
    longint p, s, lim;
    logic   of;
    exp_t   e;
    lim = longint'(1) << AW;
    p = longint'(a) * longint'(b);
    if (!m) begin
      s = p + longint'(c);
    end else begin
      s = (cl ? 0 : m_acc) + p;
      of = (s >= lim);
`ifdef MAC_PIPE_SAT_EN
      m_acc = of ? lim - 1 : s;
`else
      m_acc = of ? s - lim : s;
`endif
      m_ovf = (cl ? 1'b0 : m_ovf) | of;
    end
`ifdef MAC_PIPE_SAT_EN
    e.d = (s > 255) ? 8'hFF : 8'(s);
`else
    e.d = 8'(s & 255);
`endif
    e.acc = AW'(m_acc);
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input logic iv, input logic [7:0] ia, ib, ic,
                     input logic im, icl, ordy, output logic ok);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.c         = ic;
    bus.mode      = im;
    bus.clr       = icl;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("acc", 32'(bus.acc), 32'(e.acc));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        if (ordy) begin
          void'(exp_q.pop_front());
          n_out++;
          last_out = e.d;
        end
      end
    end
    ok = iv && bus.in_ready;
    if (ok) model(ia, ib, ic, im, icl);
  endtask

  task automatic idle();
    logic ok;
    cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, ok);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic ok;
    int   n0, idx;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.mode      = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc", 32'(bus.acc), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: latency and basic a*b+c
    n0 = n_out;
    cyc(1'b1, 8'd3, 8'd5, 8'd7, 1'b0, 1'b0, 1'b1, ok);
    chk("t1_accept", 32'(ok), 32'd1);
    idle();
    chk("t1_lat1", 32'(bus.out_valid), 32'd0);
    idle();
    chk("t1_lat2", 32'(n_out - n0), 32'd1);
    chk("t1_data", 32'(last_out), 32'd22);
    chk("t1_acc", 32'(bus.acc), 32'd0);
    chk("t1_ovf", 32'(bus.ovf), 32'd0);

    // 2: mode-0 wrap / saturation
    cyc(1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1, ok);
    drain();
`ifdef MAC_PIPE_SAT_EN
    chk("t2_data", 32'(last_out), 32'hFF);
`else
    chk("t2_data", 32'(last_out), 32'h00);
`endif

    // 3: back-to-back accumulate
    n0 = n_out;
    cyc(1'b1, 8'd2, 8'd3, 8'd0, 1'b1, 1'b1, 1'b1, ok);
    cyc(1'b1, 8'd4, 8'd5, 8'd0, 1'b1, 1'b0, 1'b1, ok);
    cyc(1'b1, 8'd1, 8'd1, 8'd0, 1'b1, 1'b0, 1'b1, ok);
    idle();
    idle();
    chk("t3_b2b", 32'(n_out - n0), 32'd3);
    chk("t3_last", 32'(last_out), 32'd27);
    chk("t3_acc", 32'(bus.acc), 32'd27);

    // 4: backpressure, capacity 2, order kept
    n0 = n_out;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(idx + 1), 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, ok);
      if (ok) idx++;
    end
    chk("t4_accepts", 32'(idx), 32'd2);
    chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 20 && (idx < 4 || exp_q.size() > 0); i++) begin
      cyc(idx < 4, 8'(idx + 1), 8'd1, 8'd0, 1'b0, 1'b0, 1'b1, ok);
      if (ok) idx++;
    end
    chk("t4_total", 32'(n_out - n0), 32'd4);
    chk("t4_last", 32'(last_out), 32'd4);

    // 5: accumulator overflow, then clear
    for (int i = 0; i < 17; i++)
      cyc(1'b1, 8'd255, 8'd255, 8'd0, 1'b1, i == 0, 1'b1, ok);
    drain();
`ifdef MAC_PIPE_SAT_EN
    chk("t5_acc", 32'(bus.acc), 32'd1048575);
`else
    chk("t5_acc", 32'(bus.acc), 32'd56849);
`endif
    chk("t5_ovf", 32'(bus.ovf), 32'd1);
    cyc(1'b1, 8'd1, 8'd1, 8'd0, 1'b1, 1'b1, 1'b1, ok);
    drain();
    chk("t5_clr_acc", 32'(bus.acc), 32'd1);
    chk("t5_clr_ovf", 32'(bus.ovf), 32'd0);

    // 6: async reset with two beats in flight
    cyc(1'b1, 8'd3, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, ok);
    cyc(1'b1, 8'd3, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, ok);
    cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, ok);
    chk("t6_pre_acc", 32'(bus.acc), 32'd10);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_acc", 32'(bus.acc), 32'd0);
    chk("t6_ovf", 32'(bus.ovf), 32'd0);
    exp_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) idle();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
          8'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 9) < 7, ok);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_pipe_n.md
Name: mac_pipe_n

Overview:
- Parametrised, pipelined successor to the 8-bit combinational multiply-add benchmark (out = a*b + c) used in the fabric's DSP benchmark suite.
- Adds valid/ready handshaking, a two-stage pipeline with backpressure, and an accumulate mode with sticky overflow.
- Targets mapping onto the fabric's DSP and logic tiles and is exercised by the same pre-configured-fabric formal and simulation flow.

Parameters:
- DATA_W, 8: width of operands a and b, and of addend c.
- OUT_W, 8: width of result output; low OUT_W bits of the internal result.
- ACC_W, 20: accumulator width; must satisfy ACC_W >= 2*DATA_W+1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- a  input  DATA_W  unsigned multiplicand.
- b  input  DATA_W  unsigned multiplier.
- c  input  DATA_W  unsigned addend; used in mode 0 only.
- mode  input  1  0 = a*b+c per sample; 1 = accumulate acc += a*b.
- clr  input  1  mode 1 only; treats the accumulator as 0 before adding, and clears ovf.
- in_valid  input  1  input beat offered.
- in_ready  output  1  input beat accepted when in_valid and in_ready are both 1.
- out_data  output  OUT_W  result.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts; beat leaves when out_valid and out_ready are both 1.
- acc  output  ACC_W  current accumulator value.
- ovf  output  1  sticky accumulator overflow flag.

Behaviour:
- Reset (reset=0, asynchronous): s1_valid, out_valid, out_data, acc and ovf all go to 0. in_ready = 1 once reset is released. Any in-flight beats are discarded.
- Stage 1 register: captures a, b, c, mode and clr on accept; sets s1_valid.
- Stage 2 / output register: computes the result from the stage-1 contents; holds out_data and out_valid.
- Advance rule:
  - s2_free = !out_valid || out_ready.
  - s1 moves to s2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready; that path is intended.
- Latency: 2 cycles from accept edge to out_valid=1 when not stalled.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Capacity: at most 2 beats in flight. Order is strictly preserved and no beat is dropped or duplicated under any stall pattern.
- Arithmetic: all operands unsigned; prod = a*b is 2*DATA_W bits.
  - Mode 0: sum = prod + zero-extended c, 2*DATA_W+1 bits. out_data = sum[OUT_W-1:0]. acc and ovf are unchanged.
  - Mode 1: base = clr ? 0 : acc; nsum = base + prod, ACC_W+1 bits.
  - Mode 1 updates: acc <= nsum[ACC_W-1:0]; out_data = nsum[OUT_W-1:0].
  - Mode 1 ovf: ovf <= (clr ? 0 : ovf) | nsum[ACC_W].
- acc and ovf update only on the edge where the mode-1 beat enters stage 2, never while stalled.
- Mode may change beat-to-beat; a mode-0 beat between mode-1 beats leaves acc intact.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous accept, advance and output-drain in one cycle is legal; the pipeline shifts without bubbles.

Optional Feature:
- Macro: MAC_PIPE_SAT_EN.
- Defined:
  - out_data saturates to all-ones when the mode-0 sum or mode-1 nsum exceeds 2^OUT_W-1.
  - In mode 1, on overflow acc saturates to 2^ACC_W-1 instead of wrapping; ovf is still set.
- Undefined: wrap-around as specified in Behaviour. No saturation logic is instantiated.

Test Plan (DATA_W=8, OUT_W=8, ACC_W=20):
1. Mode 0, a=3, b=5, c=7, out_ready=1 -> out_valid high 2 cycles after accept, out_data=22; acc=0, ovf=0.
2. Mode 0, a=255, b=255, c=255 (sum 0xFF00) -> out_data=0x00; with MAC_PIPE_SAT_EN, out_data=0xFF.
3. Mode 1, beats (2,3,clr=1), (4,5), (1,1) back-to-back -> out_data 6, 26, 27 on consecutive cycles; acc=27.
4. out_ready=0 for 6 cycles while in_valid held with 4 beats (mode 0: 1*1+0, 2*1+0, 3*1+0, 4*1+0):
   - in_ready drops after 2 accepts.
   - Release out_ready -> outputs 1, 2, 3, 4 in order; no loss or duplicates.
5. Mode 1, clr on first beat, 17 beats of a=b=255 (total 1,105,425 > 2^20-1):
   - ovf rises on the 17th beat; acc=56,849.
   - Next beat with clr=1, a=b=1 -> acc=1, ovf=0.
   - With MAC_PIPE_SAT_EN, acc=1,048,575 after the 17th beat.
6. Assert reset=0 mid-stream with 2 beats in flight -> out_valid, acc and ovf are 0 immediately, before the next clk edge; after release, in_ready=1 and no stale beat ever appears at the output.
